// File: rtl/vc_assoc_pkg.sv
// Shared types and constants for the fully-associative victim cache.
// Optional statistics counters are built only when VC_STATS_EN is defined.
package vc_assoc_pkg;

  localparam int VC_ADDR_W   = 32;
  localparam int VC_LINE_W   = 128;
  localparam int VC_OFFSET_W = 4;
  localparam int VC_TAG_W    = VC_ADDR_W - VC_OFFSET_W;
  localparam int VC_CNT_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WB
  } vc_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_LINE_W-1:0] data;
  } vc_entry_t;

  typedef struct packed {
    logic [VC_ADDR_W-1:0] addr;
    logic [VC_LINE_W-1:0] data;
  } vc_wb_t;

  function automatic logic [VC_CNT_W-1:0] vc_sat_inc(input logic [VC_CNT_W-1:0] v);
    return (&v) ? v : v + VC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/vc_plru_tree.sv
// Tree pseudo-LRU: NUM_WAYS-1 node bits, updated on every write to point away
// from the written way; victim_o follows the node bits from the root.
module vc_plru_tree #(
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [$clog2(NUM_WAYS)-1:0] way_i,
  output logic [$clog2(NUM_WAYS)-1:0] victim_o
);

  localparam int LVL = $clog2(NUM_WAYS);

  logic [NUM_WAYS-2:0] tree_q, tree_d;
  logic [LVL:0]        node;
  logic [LVL-1:0]      upd_node;

  // Heap layout: node n has children 2n+1 (bit 0, left) and 2n+2 (bit 1, right).
  always_comb begin
    node = '0;
    for (int l = 0; l < LVL; l++) begin
      node = (node << 1) + (LVL+1)'(1) + (LVL+1)'(tree_q[node[LVL-1:0]]);
    end
    // Leaf index is NUM_WAYS-1+way, so modulo NUM_WAYS the way is leaf+1.
    victim_o = node[LVL-1:0] + LVL'(1);
  end

  always_comb begin
    tree_d   = tree_q;
    upd_node = '0;
    if (we_i) begin
      for (int l = 0; l < LVL; l++) begin
        upd_node         = LVL'((2 ** l) - 1) + LVL'(way_i >> (LVL - l));
        tree_d[upd_node] = ~way_i[LVL-1-l];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tree_q <= '0;
    else         tree_q <= tree_d;
  end

endmodule

// File: rtl/victim_cache_assoc.sv
// Fully-associative victim cache between L1 and the next level: lookup, insert/swap,
// pLRU replacement with dirty write-back. Define VC_STATS_EN for access/hit/miss counters.
module victim_cache_assoc
  import vc_assoc_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int ADDR_W   = VC_ADDR_W,
  parameter int LINE_W   = VC_LINE_W,
  parameter int OFFSET_W = VC_OFFSET_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lookup_valid_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_ready_o,
  input  logic              evict_valid_i,
  input  logic [ADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0] evict_data_i,
  input  logic              evict_dirty_i,
  output logic              evict_ready_o,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [LINE_W-1:0] resp_data_o,
  output logic              resp_dirty_o,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [LINE_W-1:0] wb_data_o,
  input  logic              wb_ready_i,
  output logic [31:0]       no_acc_o,
  output logic [31:0]       no_hit_o,
  output logic [31:0]       no_miss_o
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int WAY_W = $clog2(NUM_WAYS);

  vc_state_e   state_q, state_d;
  vc_entry_t   entries_q [NUM_WAYS];
  vc_entry_t   entries_d [NUM_WAYS];
  vc_wb_t      wb_q, wb_d;
  logic        wb_pending_q, wb_pending_d;
  logic        resp_pending_q, resp_pending_d;
  logic        resp_hit_q, resp_hit_d;
  logic        resp_dirty_q, resp_dirty_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;

  logic [TAG_W-1:0] lk_tag, ev_tag;
  logic             lk_hit, ev_match, inv_any, displace, wb_capture;
  logic [WAY_W-1:0] lk_idx, ev_idx, inv_idx, tgt_idx, plru_victim;
  logic             acc_lookup, acc_evict;
  logic             unused_ok;

  assign unused_ok = ^{lookup_addr_i[OFFSET_W-1:0], evict_addr_i[OFFSET_W-1:0]};

  assign lookup_ready_o = (state_q == IDLE);
  assign evict_ready_o  = (state_q == IDLE);
  assign acc_lookup     = lookup_valid_i & lookup_ready_o;
  assign acc_evict      = evict_valid_i & evict_ready_o;
  assign lk_tag         = lookup_addr_i[ADDR_W-1:OFFSET_W];
  assign ev_tag         = evict_addr_i[ADDR_W-1:OFFSET_W];

  // Descending scans leave the lowest matching index selected.
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    ev_match = 1'b0;
    ev_idx   = '0;
    inv_any  = 1'b0;
    inv_idx  = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (entries_q[i].valid && entries_q[i].tag == lk_tag) begin
        lk_hit = 1'b1;
        lk_idx = WAY_W'(i);
      end
      if (entries_q[i].valid && entries_q[i].tag == ev_tag) begin
        ev_match = 1'b1;
        ev_idx   = WAY_W'(i);
      end
      if (!entries_q[i].valid) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(i);
      end
    end
  end

  always_comb begin
    displace = 1'b0;
    tgt_idx  = plru_victim;
    if (ev_match)                  tgt_idx = ev_idx;
    else if (acc_lookup && lk_hit) tgt_idx = lk_idx;
    else if (inv_any)              tgt_idx = inv_idx;
    else                           displace = 1'b1;
  end

  assign wb_capture = acc_evict & displace & entries_q[plru_victim].dirty;

  vc_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (acc_evict),
    .way_i    (tgt_idx),
    .victim_o (plru_victim)
  );

  // Insert is applied after the lookup invalidate so a same-tag insert wins.
  always_comb begin
    entries_d = entries_q;
    if (acc_lookup && lk_hit) entries_d[lk_idx].valid = 1'b0;
    if (acc_evict) begin
      entries_d[tgt_idx].valid = 1'b1;
      entries_d[tgt_idx].dirty = evict_dirty_i | (ev_match & entries_q[tgt_idx].dirty);
      entries_d[tgt_idx].tag   = ev_tag;
      entries_d[tgt_idx].data  = evict_data_i;
    end
  end

  always_comb begin
    state_d        = state_q;
    wb_d           = wb_q;
    wb_pending_d   = wb_pending_q;
    resp_pending_d = resp_pending_q;
    resp_hit_d     = resp_hit_q;
    resp_dirty_d   = resp_dirty_q;
    resp_data_d    = resp_data_q;
    case (state_q)
      IDLE: begin
        if (acc_lookup || acc_evict) begin
          state_d        = RESP;
          resp_pending_d = acc_lookup;
          resp_hit_d     = acc_lookup & lk_hit;
          resp_dirty_d   = acc_lookup & lk_hit & entries_q[lk_idx].dirty;
          resp_data_d    = (acc_lookup && lk_hit) ? entries_q[lk_idx].data : '0;
          wb_pending_d   = wb_capture;
          if (wb_capture) begin
            wb_d.addr = {entries_q[plru_victim].tag, {OFFSET_W{1'b0}}};
            wb_d.data = entries_q[plru_victim].data;
          end
        end
      end
      RESP: begin
        state_d        = wb_pending_q ? WB : IDLE;
        wb_pending_d   = 1'b0;
        resp_pending_d = 1'b0;
      end
      WB: begin
        if (wb_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      entries_q      <= '{default: '0};
      wb_q           <= '0;
      wb_pending_q   <= 1'b0;
      resp_pending_q <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_dirty_q   <= 1'b0;
      resp_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      entries_q      <= entries_d;
      wb_q           <= wb_d;
      wb_pending_q   <= wb_pending_d;
      resp_pending_q <= resp_pending_d;
      resp_hit_q     <= resp_hit_d;
      resp_dirty_q   <= resp_dirty_d;
      resp_data_q    <= resp_data_d;
    end
  end

  assign resp_valid_o = (state_q == RESP) & resp_pending_q;
  assign resp_hit_o   = resp_valid_o & resp_hit_q;
  assign resp_dirty_o = resp_valid_o & resp_dirty_q;
  assign resp_data_o  = resp_valid_o ? resp_data_q : '0;
  assign wb_valid_o   = (state_q == WB);
  assign wb_addr_o    = wb_valid_o ? wb_q.addr : '0;
  assign wb_data_o    = wb_valid_o ? wb_q.data : '0;

`ifdef VC_STATS_EN
  logic [VC_CNT_W-1:0] acc_cnt_q, acc_cnt_d, hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (acc_lookup) begin
      acc_cnt_d = vc_sat_inc(acc_cnt_q);
      if (lk_hit) hit_cnt_d  = vc_sat_inc(hit_cnt_q);
      else        miss_cnt_d = vc_sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign no_acc_o  = acc_cnt_q;
  assign no_hit_o  = hit_cnt_q;
  assign no_miss_o = miss_cnt_q;
`else
  assign no_acc_o  = '0;
  assign no_hit_o  = '0;
  assign no_miss_o = '0;
`endif

endmodule

// File: tb/tb_victim_cache_assoc.sv
// Directed self-checking bench for victim_cache_assoc; counter expectations
// follow whether VC_STATS_EN is defined.
module tb_victim_cache_assoc;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         lookup_valid_i = 1'b0;
  logic [31:0]  lookup_addr_i = '0;
  logic         lookup_ready_o;
  logic         evict_valid_i = 1'b0;
  logic [31:0]  evict_addr_i = '0;
  logic [127:0] evict_data_i = '0;
  logic         evict_dirty_i = 1'b0;
  logic         evict_ready_o;
  logic         resp_valid_o, resp_hit_o, resp_dirty_o;
  logic [127:0] resp_data_o;
  logic         wb_valid_o;
  logic [31:0]  wb_addr_o;
  logic [127:0] wb_data_o;
  logic         wb_ready_i = 1'b0;
  logic [31:0]  no_acc_o, no_hit_o, no_miss_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef VC_STATS_EN
  localparam logic [31:0] CNT_ON = 32'd1;
`else
  localparam logic [31:0] CNT_ON = 32'd0;
`endif

  victim_cache_assoc dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i), .lookup_ready_o(lookup_ready_o),
    .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
    .evict_dirty_i(evict_dirty_i), .evict_ready_o(evict_ready_o),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_data_o(resp_data_o),
    .resp_dirty_o(resp_dirty_o),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i),
    .no_acc_o(no_acc_o), .no_hit_o(no_hit_o), .no_miss_o(no_miss_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] dline(input logic [31:0] tagbits, input logic [31:0] a);
    return {4{tagbits | a}};
  endfunction

  // Drives one operation in an IDLE cycle and returns at the negedge of the RESP cycle.
  task automatic op(input logic lv, input logic [31:0] la, input logic ev,
                    input logic [31:0] ea, input logic [127:0] ed, input logic edirty);
    @(negedge clk_i);
    lookup_valid_i = lv; lookup_addr_i = la;
    evict_valid_i = ev; evict_addr_i = ea; evict_data_i = ed; evict_dirty_i = edirty;
    $display("op lookup=%0b addr=%h insert=%0b addr=%h dirty=%0b", lv, la, ev, ea, edirty);
    @(posedge clk_i);
    @(negedge clk_i);
    lookup_valid_i = 1'b0; evict_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    vectors++; if (lookup_ready_o !== 1'b1 || evict_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_readys got %0b%0b want 11", lookup_ready_o, evict_ready_o); end
    vectors++; if (resp_valid_o !== 1'b0 || wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valids got %0b%0b want 00", resp_valid_o, wb_valid_o); end
    vectors++; if (no_acc_o !== 32'd0 || no_hit_o !== 32'd0 || no_miss_o !== 32'd0) begin miscompares++; $display("FAIL rst_counters got %0d/%0d/%0d want 0/0/0", no_acc_o, no_hit_o, no_miss_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_miss;
    op(1'b1, 32'h1000, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_valid_o !== 1'b1 || resp_hit_o !== 1'b0) begin miscompares++; $display("FAIL miss_resp got v=%0b h=%0b want v=1 h=0", resp_valid_o, resp_hit_o); end
    vectors++; if (resp_data_o !== 128'd0) begin miscompares++; $display("FAIL miss_data got %h want 0", resp_data_o); end
    vectors++; if (lookup_ready_o !== 1'b0) begin miscompares++; $display("FAIL resp_ready got %0b want 0", lookup_ready_o); end
    vectors++; if (no_acc_o !== CNT_ON || no_miss_o !== CNT_ON || no_hit_o !== 32'd0) begin miscompares++; $display("FAIL miss_counters got %0d/%0d/%0d want %0d/0/%0d", no_acc_o, no_hit_o, no_miss_o, CNT_ON, CNT_ON); end
    @(negedge clk_i);
    vectors++; if (resp_valid_o !== 1'b0 || lookup_ready_o !== 1'b1) begin miscompares++; $display("FAIL resp_one_cycle got v=%0b r=%0b want v=0 r=1", resp_valid_o, lookup_ready_o); end
  endtask

  task automatic test_hit_invalidate;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    op(1'b0, 32'h0, 1'b1, 32'h2000, a5, 1'b0);
    vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL insert_noresp got %0b want 0", resp_valid_o); end
    op(1'b1, 32'h2004, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_hit_o !== 1'b1 || resp_data_o !== a5 || resp_dirty_o !== 1'b0) begin miscompares++; $display("FAIL hit_2004 got h=%0b d=%h dirty=%0b want h=1 d=%h dirty=0", resp_hit_o, resp_data_o, resp_dirty_o, a5); end
    op(1'b1, 32'h2000, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_valid_o !== 1'b1 || resp_hit_o !== 1'b0) begin miscompares++; $display("FAIL invalidated got v=%0b h=%0b want v=1 h=0", resp_valid_o, resp_hit_o); end
  endtask

  task automatic test_fill_wb;
    logic [31:0] held_addr;
    logic [127:0] held_data;
    for (int i = 0; i < 4; i++) op(1'b0, 32'h0, 1'b1, 32'(i * 16), dline(32'hD000_0000, 32'(i * 16)), 1'b1);
    op(1'b0, 32'h0, 1'b1, 32'h40, dline(32'hD000_0000, 32'h40), 1'b1);
    vectors++; if (wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL wb_early got %0b want 0", wb_valid_o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      held_addr = wb_addr_o; held_data = wb_data_o;
      vectors++; if (wb_valid_o !== 1'b1 || wb_addr_o !== 32'h0 || wb_data_o !== dline(32'hD000_0000, 32'h0)) begin miscompares++; $display("FAIL wb_hold%0d got v=%0b a=%h d=%h want v=1 a=0 d=%h", c, wb_valid_o, held_addr, held_data, dline(32'hD000_0000, 32'h0)); end
      vectors++; if (lookup_ready_o !== 1'b0 || evict_ready_o !== 1'b0) begin miscompares++; $display("FAIL wb_readys%0d got %0b%0b want 00", c, lookup_ready_o, evict_ready_o); end
    end
    wb_ready_i = 1'b1;
    @(negedge clk_i);
    wb_ready_i = 1'b0;
    vectors++; if (wb_valid_o !== 1'b0 || lookup_ready_o !== 1'b1) begin miscompares++; $display("FAIL wb_done got v=%0b r=%0b want v=0 r=1", wb_valid_o, lookup_ready_o); end
  endtask

  task automatic test_swap;
    op(1'b1, 32'h10, 1'b1, 32'h50, dline(32'hD000_0000, 32'h50), 1'b1);
    vectors++; if (resp_hit_o !== 1'b1 || resp_data_o !== dline(32'hD000_0000, 32'h10) || resp_dirty_o !== 1'b1) begin miscompares++; $display("FAIL swap_resp got h=%0b d=%h dirty=%0b want h=1 d=%h dirty=1", resp_hit_o, resp_data_o, resp_dirty_o, dline(32'hD000_0000, 32'h10)); end
    @(negedge clk_i);
    vectors++; if (wb_valid_o !== 1'b0 || lookup_ready_o !== 1'b1) begin miscompares++; $display("FAIL swap_nowb got v=%0b r=%0b want v=0 r=1", wb_valid_o, lookup_ready_o); end
  endtask

  task automatic test_same_tag;
    op(1'b1, 32'h20, 1'b1, 32'h20, dline(32'hE000_0000, 32'h20), 1'b0);
    vectors++; if (resp_hit_o !== 1'b1 || resp_data_o !== dline(32'hD000_0000, 32'h20)) begin miscompares++; $display("FAIL same_tag_old got h=%0b d=%h want h=1 d=%h", resp_hit_o, resp_data_o, dline(32'hD000_0000, 32'h20)); end
    @(negedge clk_i);
    vectors++; if (wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL same_tag_nowb got %0b want 0", wb_valid_o); end
  endtask

  task automatic test_overwrite;
    op(1'b0, 32'h0, 1'b1, 32'h30, dline(32'hE000_0000, 32'h30), 1'b0);
    @(negedge clk_i);
    vectors++; if (wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL overwrite_nowb got %0b want 0", wb_valid_o); end
    op(1'b1, 32'h30, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_hit_o !== 1'b1 || resp_dirty_o !== 1'b1 || resp_data_o !== dline(32'hE000_0000, 32'h30)) begin miscompares++; $display("FAIL overwrite_lk got h=%0b dirty=%0b d=%h want h=1 dirty=1 d=%h", resp_hit_o, resp_dirty_o, resp_data_o, dline(32'hE000_0000, 32'h30)); end
    op(1'b1, 32'h20, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_hit_o !== 1'b1 || resp_dirty_o !== 1'b1 || resp_data_o !== dline(32'hE000_0000, 32'h20)) begin miscompares++; $display("FAIL same_tag_new got h=%0b dirty=%0b d=%h want h=1 dirty=1 d=%h", resp_hit_o, resp_dirty_o, resp_data_o, dline(32'hE000_0000, 32'h20)); end
    op(1'b1, 32'h50, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_hit_o !== 1'b1 || resp_data_o !== dline(32'hD000_0000, 32'h50)) begin miscompares++; $display("FAIL swapped_in got h=%0b d=%h want h=1 d=%h", resp_hit_o, resp_data_o, dline(32'hD000_0000, 32'h50)); end
    op(1'b1, 32'h10, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_hit_o !== 1'b0) begin miscompares++; $display("FAIL swapped_out got h=%0b want 0", resp_hit_o); end
    op(1'b1, 32'h40, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_hit_o !== 1'b1 || resp_data_o !== dline(32'hD000_0000, 32'h40)) begin miscompares++; $display("FAIL replaced_way got h=%0b d=%h want h=1 d=%h", resp_hit_o, resp_data_o, dline(32'hD000_0000, 32'h40)); end
  endtask

  task automatic test_reset_wb;
    @(negedge clk_i); rst_ni = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) op(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i * 16), dline(32'hC000_0000, 32'(i * 16)), 1'b1);
    op(1'b0, 32'h0, 1'b1, 32'h140, dline(32'hC000_0000, 32'h40), 1'b1);
    @(negedge clk_i);
    vectors++; if (wb_valid_o !== 1'b1 || wb_addr_o !== 32'h100) begin miscompares++; $display("FAIL pre_reset_wb got v=%0b a=%h want v=1 a=100", wb_valid_o, wb_addr_o); end
    rst_ni = 1'b0;
    #1;
    vectors++; if (wb_valid_o !== 1'b0 || wb_addr_o !== 32'h0 || lookup_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_wb got v=%0b a=%h r=%0b want v=0 a=0 r=1", wb_valid_o, wb_addr_o, lookup_ready_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    op(1'b1, 32'h110, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_valid_o !== 1'b1 || resp_hit_o !== 1'b0) begin miscompares++; $display("FAIL post_reset_110 got v=%0b h=%0b want v=1 h=0", resp_valid_o, resp_hit_o); end
    op(1'b1, 32'h140, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_hit_o !== 1'b0) begin miscompares++; $display("FAIL post_reset_140 got h=%0b want 0", resp_hit_o); end
    op(1'b1, 32'h110, 1'b0, 32'h0, '0, 1'b0);
    vectors++; if (resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL pre_reset_resp got %0b want 1", resp_valid_o); end
    vectors++; if (no_acc_o !== 32'd3 * CNT_ON || no_miss_o !== 32'd3 * CNT_ON || no_hit_o !== 32'd0) begin miscompares++; $display("FAIL post_reset_counters got %0d/%0d/%0d want %0d/0/%0d", no_acc_o, no_hit_o, no_miss_o, 3 * CNT_ON, 3 * CNT_ON); end
    rst_ni = 1'b0;
    #1;
    vectors++; if (resp_valid_o !== 1'b0 || resp_data_o !== 128'd0) begin miscompares++; $display("FAIL reset_in_resp got v=%0b d=%h want v=0 d=0", resp_valid_o, resp_data_o); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    test_reset();
    test_miss();
    test_hit_invalidate();
    test_fill_wb();
    test_swap();
    test_same_tag();
    test_overwrite();
    test_reset_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
